muldiv_hilo_ctrl: RTL
=====================

// Module: muldiv_hilo_ctrl
// PURPOSE
//  EX-stage sequencer for the shared multiplier (fixed latency) and iterative divider (start/ready).
//  Accepts one mult/multu/div/divu/mthi/mtlo op at a time from EX and drives the mul/div unit inputs.
//  Raises stallreq while a multi-cycle op is in flight and owns the architectural HI/LO registers.
//  Sits between EX decode and the mul/div units; stallreq feeds the stall controller.
// PARAMETERS
//  MUL_LAT      2   cycles from mul operands valid to mul_result valid (>=1)
//  DIV_MAX_CYC  40  divider watchdog limit in cycles (used only with MULDIV_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  resetn       in   1   reset, asynchronous, active-low
//  op_valid     in   1   EX holds a mul/div/hilo op; op_* held stable while stallreq=1
//  op_code      in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others = no-op
//  op_src1      in   32  rs operand (dividend / mthi-mtlo data)
//  op_src2      in   32  rt operand (divisor)
//  flush        in   1   kill the in-flight op
//  mul_signed   out  1   to multiplier
//  mul_ina      out  32  to multiplier (= op_src1)
//  mul_inb      out  32  to multiplier (= op_src2)
//  mul_result   in   64  {hi,lo} product
//  div_start    out  1   to divider; held high until div_ready
//  div_signed   out  1   to divider
//  div_op1      out  32  dividend
//  div_op2      out  32  divisor
//  div_annul    out  1   one-cycle abort pulse to divider
//  div_result   in   64  {remainder,quotient}
//  div_ready    in   1   divider result valid (one cycle)
//  stallreq     out  1   stall request to pipeline
//  hi           out  32  HI register
//  lo           out  32  LO register
//  timeout_err  out  1   sticky divider-timeout flag
// BEHAVIOUR
//  Reset: async on resetn=0; state IDLE; hi=lo=0; all outputs 0; counters 0.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE: accept = op_valid & ~flush.
//   - mult/multu: stallreq=1 (combinational, same cycle); cnt<=MUL_LAT-1; go MUL.
//   - div/divu: stallreq=1; div_start=1 (same cycle); go DIV.
//   - mthi/mtlo: hi/lo <= op_src1 at that edge; no stall; stay IDLE.
//  MUL: stallreq=1 while cnt!=0, cnt decrements. At cnt==0: {hi,lo}<=mul_result; go DONE.
//   Total stall = MUL_LAT cycles incl. accept cycle when MUL_LAT=1.
//  DIV: stallreq=1, div_start=1, operands driven; on div_ready: hi<=div_result[63:32],
//   lo<=div_result[31:0], stallreq=0 in that same cycle, go DONE.
//  DONE: stallreq=0, no accept (op_valid is still the finished op); go IDLE next cycle.
//  Signedness: mul_signed/div_signed = (op_code[0]==0); unsigned for multu/divu.
//  Zero divisor: passed to divider unchanged; hi/lo take whatever it returns.
//  Non-DIV states: div_op1/div_op2/div_start/div_signed = 0; mul_* driven combinationally always.
//  flush (any state): priority over accept and over div_ready; no hi/lo write; stallreq=0;
//   div_annul=1 for one cycle if state DIV; next state IDLE.
//  op_valid during MUL/DIV/DONE ignored; undefined op_code ignored (no stall).
// CONFIGURATION
//  MULDIV_TIMEOUT_EN defined: cycle counter in DIV; if DIV_MAX_CYC cycles pass without
//   div_ready: div_annul=1 for one cycle, timeout_err<=1 (sticky until reset), hi/lo
//   unchanged, go DONE. div_ready on the limit cycle wins over timeout.
//  Not defined: no counter; DIV waits indefinitely; timeout_err tied 0.
// TESTING
//  mult src1=0xFFFFFFFD src2=5 -> stallreq MUL_LAT cycles, hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  multu 0xFFFFFFFF x 2 -> hi=0x00000001 lo=0xFFFFFFFE; DONE cycle does not restart op.
//  divu 100/7, model ready after 33 cyc -> div_start high 33 cyc, hi=2 lo=14, stallreq drops on ready.
//  div 0xFFFFFFF9/2 -> hi=0xFFFFFFFF lo=0xFFFFFFFD; mthi 0x1234 next cycle -> hi=0x1234, no stall.
//  flush on cycle 10 of div with ready same cycle -> div_annul 1 cyc, hi/lo unchanged, IDLE.
//  TIMEOUT_EN, DIV_MAX_CYC=40, ready never -> annul at cycle 40, timeout_err=1; resetn mid-op -> all 0.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-side op bus plus multiplier/divider unit handshake for the HI/LO sequencer.
// slave = the sequencer, master = EX stage and mul/div units.
interface muldiv_hilo_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        flush;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        timeout_err;

    modport slave (
        input  op_valid, op_code, op_src1, op_src2, flush,
        input  mul_result, div_result, div_ready,
        output mul_signed, mul_ina, mul_inb,
        output div_start, div_signed, div_op1, div_op2, div_annul,
        output stallreq, hi, lo, timeout_err
    );

    modport master (
        output op_valid, op_code, op_src1, op_src2, flush,
        output mul_result, div_result, div_ready,
        input  mul_signed, mul_ina, mul_inb,
        input  div_start, div_signed, div_op1, div_op2, div_annul,
        input  stallreq, hi, lo, timeout_err
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage mul/div sequencer owning HI/LO; optional divider watchdog under MULDIV_TIMEOUT_EN.
// Latency: mult stalls MUL_LAT cycles incl. accept; div stalls until div_ready; mthi/mtlo write at the edge.
// Backpressure: stallreq held while an op is in flight, dropped in the cycle the result is captured.
module muldiv_hilo_ctrl #(
    parameter int MUL_LAT     = 2,
    parameter int DIV_MAX_CYC = 40
) (
    input  logic              clk,
    input  logic              resetn,
    muldiv_hilo_ctrl_if.slave bus
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic accept, is_mul, is_div, acc_mul, acc_div, div_tmo;

`ifdef MULDIV_TIMEOUT_EN
    localparam int TW = $clog2(DIV_MAX_CYC + 1);
    // tcnt = divider cycles already spent (accept cycle counts as the first)
    logic [TW-1:0] tcnt;
    logic          terr_q;
`endif

    always_comb begin
        is_mul  = (bus.op_code[2:1] == 2'b00);
        is_div  = (bus.op_code[2:1] == 2'b01);
        accept  = resetn && (state == S_IDLE) && bus.op_valid && !bus.flush;
        acc_mul = accept && is_mul;
        acc_div = accept && is_div;
`ifdef MULDIV_TIMEOUT_EN
        div_tmo = (state == S_DIV) && !bus.flush && !bus.div_ready &&
                  (tcnt == TW'(DIV_MAX_CYC - 1));
`else
        div_tmo = 1'b0;
`endif

        bus.stallreq  = acc_mul || acc_div ||
                        ((state == S_MUL) && (cnt != '0) && !bus.flush) ||
                        ((state == S_DIV) && !bus.flush && !bus.div_ready && !div_tmo);
        // an aborted divide drops start in the same cycle annul is raised
        bus.div_start  = acc_div || ((state == S_DIV) && !bus.flush && !div_tmo);
        bus.div_annul  = (state == S_DIV) && (bus.flush || div_tmo);
        bus.div_signed = bus.div_start && !bus.op_code[0];
        bus.div_op1    = bus.div_start ? bus.op_src1 : 32'd0;
        bus.div_op2    = bus.div_start ? bus.op_src2 : 32'd0;

        bus.mul_signed = !bus.op_code[0];
        bus.mul_ina    = bus.op_src1;
        bus.mul_inb    = bus.op_src2;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
`ifdef MULDIV_TIMEOUT_EN
            tcnt   <= '0;
            terr_q <= 1'b0;
`endif
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (acc_mul) begin
                        cnt   <= CW'(MUL_LAT - 1);
                        state <= S_MUL;
                    end else if (acc_div) begin
`ifdef MULDIV_TIMEOUT_EN
                        tcnt  <= TW'(1);
`endif
                        state <= S_DIV;
                    end else if (accept && (bus.op_code == 3'b100)) begin
                        hi_q <= bus.op_src1;
                    end else if (accept && (bus.op_code == 3'b101)) begin
                        lo_q <= bus.op_src1;
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        hi_q  <= bus.mul_result[63:32];
                        lo_q  <= bus.mul_result[31:0];
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    if (bus.div_ready) begin
                        hi_q  <= bus.div_result[63:32];
                        lo_q  <= bus.div_result[31:0];
                        state <= S_DONE;
                    end else if (div_tmo) begin
`ifdef MULDIV_TIMEOUT_EN
                        terr_q <= 1'b1;
`endif
                        state <= S_DONE;
                    end else begin
`ifdef MULDIV_TIMEOUT_EN
                        tcnt <= tcnt + TW'(1);
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
`ifdef MULDIV_TIMEOUT_EN
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule
